// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - MULTU/DIVU sequencer driving the shared ALU for 32 iterations
module muldiv_sequencer #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] ADD_OP = 3'b010,
  parameter logic [2:0] SUB_OP = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_w
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic             op_r;
  logic [4:0]       count;
  logic [WIDTH-1:0] mreg;

  logic [WIDTH-1:0] div_r;
  logic             div_take;
  logic             mul_carry;

  // Partial remainder is 33 bits wide; hi[msb] is its top bit, so msb set always subtracts.
  assign div_r     = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign div_take  = hi[WIDTH-1] | (div_r >= mreg);
  assign mul_carry = (alu_w < hi);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ADD_OP;
    if (state == CALC) begin
      if (op_r) begin
        alu_a  = div_r;
        alu_b  = mreg;
        alu_op = SUB_OP;
      end else begin
        alu_a  = hi;
        alu_b  = lo[0] ? mreg : '0;
        alu_op = ADD_OP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_r    <= 1'b0;
      count   <= '0;
      mreg    <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            count <= '0;
            mreg  <= src_b;
            busy  <= 1'b1;
            if (op && (src_b == '0)) begin
              hi      <= src_a;
              lo      <= '1;
              done    <= 1'b1;
              alu_req <= 1'b0;
              state   <= DONE;
            end else begin
              hi      <= '0;
              lo      <= src_a;
              alu_req <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (op_r) begin
            hi <= div_take ? alu_w : div_r;
            lo <= {lo[WIDTH-2:0], div_take};
          end else begin
            hi <= {mul_carry, alu_w[WIDTH-1:1]};
            lo <= {alu_w[0], lo[WIDTH-1:1]};
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            alu_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed bench for muldiv_sequencer with behavioural ALU
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_w;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;

  int done_cyc, busy_cnt, req_cnt;

  always #5 clk = ~clk;

  assign alu_w = (alu_op == 3'b010) ? alu_a + alu_b :
                 (alu_op == 3'b110) ? alu_a - alu_b : 32'h0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_w(alu_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one operation and watches it cycle by cycle; cycle 1 follows the accepting edge.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input int abort_at,
                        output int dcyc, output int bcnt, output int rcnt);
    dcyc = 0;
    bcnt = 0;
    rcnt = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      bcnt += int'(busy);
      rcnt += int'(alu_req);
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (cyc == pulse_at) begin
        start = 1'b1; op = ~o; src_a = 32'd99; src_b = 32'd9;
      end
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_req", {31'b0, alu_req}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        dcyc = -1;
        @(negedge clk);
        rst = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_req", {31'b0, alu_req}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_aluop", {29'b0, alu_op}, 32'h2);
    chk("rst_alua", alu_a, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 32'd6, 32'd7, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("mul6x7_lat", done_cyc, 32'd33);
    chk("mul6x7_busy", busy_cnt, 32'd33);
    chk("mul6x7_req", req_cnt, 32'd32);
    chk("mul6x7_hi", hi, 32'h0);
    chk("mul6x7_lo", lo, 32'd42);
    @(posedge clk); #1;
    chk("idle_done", {31'b0, done}, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("idle_hold_lo", lo, 32'd42);
    chk("idle_aluop", {29'b0, alu_op}, 32'h2);

    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("mulmax_lat", done_cyc, 32'd33);
    chk("mulmax_hi", hi, 32'hFFFFFFFE);
    chk("mulmax_lo", lo, 32'h00000001);
    @(posedge clk); #1;

    run_op(1'b1, 32'd100, 32'd7, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("div100_lat", done_cyc, 32'd33);
    chk("div100_hi", hi, 32'd2);
    chk("div100_lo", lo, 32'd14);
    @(posedge clk); #1;

    run_op(1'b1, 32'h80000000, 32'd3, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("divmsb_hi", hi, 32'd2);
    chk("divmsb_lo", lo, 32'h2AAAAAAA);
    @(posedge clk); #1;

    run_op(1'b1, 32'd5, 32'd0, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("div0_lat", done_cyc, 32'd1);
    chk("div0_req", req_cnt, 32'd0);
    chk("div0_hi", hi, 32'd5);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    @(posedge clk); #1;

    run_op(1'b0, 32'd3, 32'd4, 10, 0, done_cyc, busy_cnt, req_cnt);
    chk("ign_lat", done_cyc, 32'd33);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd12);
    @(posedge clk); #1;

    run_op(1'b1, 32'd50, 32'd8, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("b2b_lat", done_cyc, 32'd33);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd6);
    @(posedge clk); #1;

    run_op(1'b1, 32'd1000, 32'd9, 0, 15, done_cyc, busy_cnt, req_cnt);
    chk("abort_flag", done_cyc, 32'hFFFFFFFF);

    run_op(1'b0, 32'd2, 32'd3, 0, 0, done_cyc, busy_cnt, req_cnt);
    chk("post_lat", done_cyc, 32'd33);
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that implements MIPS MULTU/DIVU by sequencing the shared 32-bit ALU over 32 iterations.
- Multiply is shift-add using ALU ADD. Divide is restoring division using ALU SUB.
- Sits beside the single-cycle datapath. While active it drives the ALU operand/op mux, then delivers HI/LO to the HI/LO registers.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ADD_OP, 3'b010, ALU op code for add.
- SUB_OP, 3'b110, ALU op code for subtract.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = MULTU, 1 = DIVU; captured with start.
- src_a  input  32  multiplicand / dividend.
- src_b  input  32  multiplier / divisor.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; hi/lo valid.
- hi  output  32  product[63:32] / remainder.
- lo  output  32  product[31:0] / quotient.
- alu_req  output  1  high in CALC; datapath mux gives ALU to sequencer.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_op  output  3  ALU operation.
- alu_w  input  32  ALU result (combinational, same cycle).

Behaviour:
- Reset (rst=0, async): state=IDLE; hi, lo, divisor/mcand reg, op reg, count all 0; busy=0, done=0, alu_req=0.
- alu_a/alu_b/alu_op are combinational from registers. Outside CALC they are 0/0/ADD_OP.
- States: IDLE, CALC, DONE.
- IDLE:
  - When start=1, capture op and set count=0.
  - MULTU: hi=0, lo=src_a, mreg=src_b.
  - DIVU: hi=0, lo=src_a, mreg=src_b.
  - DIVU with src_b==0: go directly to DONE with hi=src_a, lo=32'hFFFFFFFF.
  - Otherwise go to CALC.
- CALC: one iteration per cycle, count increments. After iteration count==31, go to DONE.
- MULTU iteration:
  - alu_op=ADD_OP, alu_a=hi, alu_b = lo[0] ? mreg : 0.
  - carry = (alu_w < hi), unsigned compare.
  - hi <= {carry, alu_w[31:1]}; lo <= {alu_w[0], lo[31:1]}.
- DIVU iteration:
  - r = {hi[30:0], lo[31]}, msb = hi[31].
  - alu_op=SUB_OP, alu_a=r, alu_b=mreg.
  - If msb | (r >= mreg), unsigned compare: hi <= alu_w, lo <= {lo[30:0],1'b1}.
  - Else: hi <= r, lo <= {lo[30:0],1'b0}.
- DONE: done=1 for exactly one cycle; hi/lo hold final values; next state IDLE.
- hi/lo persist in IDLE until the next accepted start.
- Latency: start accepted at edge N; done high during cycle N+33 (32 CALC + 1 DONE). Divide-by-zero: done at N+1.
- Next start is accepted in the cycle after done (IDLE). Throughput is one operation per 34 cycles.
- start while busy=1 is ignored; no queuing; inputs not recaptured.
- src_a/src_b/op may change after acceptance without effect.
- Reset asserted mid-CALC aborts immediately. No done pulse; outputs return to reset values.
- Arithmetic is unsigned only. Signed MULT/DIV are out of scope (handled by sign fix-up elsewhere).

Test Plan:
- Bench includes a behavioural ALU on alu_a/alu_b/alu_op -> alu_w.
- MULTU 6 x 7: done exactly 33 cycles after start; hi=0, lo=42; busy high for 33 cycles; alu_req high for 32.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (checks carry path).
- DIVU 100 / 7 -> lo=14, hi=2. DIVU 0x80000000 / 3 -> lo=0x2AAAAAAA, hi=2 (checks msb path).
- DIVU 5 / 0 -> done one cycle after start; hi=5, lo=0xFFFFFFFF; alu_req never asserts.
- start pulsed again at cycle 10 of a MULTU 3x4 with different operands -> ignored; result hi=0, lo=12 at cycle 33. Back-to-back: second start in the IDLE cycle after done is accepted.
- rst low at cycle 15 of DIVU -> busy, done, alu_req, hi, lo all 0 asynchronously. After release, a new MULTU 2x3 gives lo=6.
